// File: rtl/vector_narrowing_packer_pkg.sv
// Shared types for the narrowing packer: FSM state encoding and element width.
package dragonfang_pkg;

    localparam int NARROW_ELEMENT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        COLLECT_LOW  = 2'd1,
        COLLECT_HIGH = 2'd2,
        EMIT         = 2'd3
    } packer_state_t;

endpackage

// File: rtl/vector_narrowing_packer.sv
// Packs pairs of 32-bit narrowed conversion results into 64-bit write-back words
// over a counted operation; odd counts end in a zero-padded tail word.
module vector_narrowing_packer
    import dragonfang_pkg::*;
#(
    parameter int ELEMENT_WIDTH = NARROW_ELEMENT_WIDTH,
    parameter int WORD_WIDTH    = 2 * ELEMENT_WIDTH,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   element_count,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEMENT_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    packer_state_t            state;
    logic [COUNT_WIDTH-1:0]   remaining;
    logic [COUNT_WIDTH-1:0]   remaining_dec;
    logic [ELEMENT_WIDTH-1:0] low_q;
    logic [ELEMENT_WIDTH-1:0] high_q;
    logic                     done_q;

    // Saturating decrement keeps the counter from wrapping.
    assign remaining_dec = (remaining != '0) ? remaining - 1'b1 : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            low_q     <= '0;
            high_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (element_count != '0) begin
                            remaining <= element_count;
                            state     <= COLLECT_LOW;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                COLLECT_LOW: begin
                    if (in_valid) begin
                        low_q     <= in_data;
                        high_q    <= '0;
                        remaining <= remaining_dec;
                        state     <= (remaining_dec == '0) ? EMIT : COLLECT_HIGH;
                    end
                end
                COLLECT_HIGH: begin
                    if (in_valid) begin
                        high_q    <= in_data;
                        remaining <= remaining_dec;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (remaining == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= COLLECT_LOW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come from registered state only.
    assign in_ready  = (state == COLLECT_LOW) || (state == COLLECT_HIGH);
    assign out_valid = (state == EMIT);
    assign out_last  = (state == EMIT) && (remaining == '0);
    assign out_data  = {high_q, low_q};
    assign busy      = (state != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_vector_narrowing_packer.sv
// Randomized and directed bench for vector_narrowing_packer against a pair-packing model.
module tb_vector_narrowing_packer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  element_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] data_q[$];
    int  p_in, p_out, bp_hold, stall_gap;
    bit  inject_start;

    vector_narrowing_packer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .element_count(element_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int i = 0; i < n; i++) data_q.push_back($urandom);
    endtask

    task automatic set_knobs(input int pi, input int po, input int hold, input int gap, input bit inj);
        p_in = pi; p_out = po; bp_hold = hold; stall_gap = gap; inject_start = inj;
    endtask

    // Model: word k = {data[2k+1] or 0, data[2k]}; a word is pending from the
    // input transfer that completes it until its output transfer.
    task automatic run_op(input int n);
        int words = (n + 1) / 2;
        int ptr = 0, idx = 0, cyc = 0, hold_left = bp_hold, gap_left = 0;
        bit pending = 0, done_due = 0, injected = 0;
        logic [63:0] exp_word;
        @(negedge clock);
        start = 1'b1; element_count = n[7:0]; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            chk("zero_out_valid", out_valid, 0);
            @(negedge clock);
            chk("zero_done_clear", done, 0);
            chk("zero_out_valid2", out_valid, 0);
            return;
        end
        forever begin
            chk("busy", busy, (idx < words));
            chk("done", done, done_due);
            if (idx == words) break;
            chk("out_valid", out_valid, pending);
            chk("in_ready", in_ready, !pending);
            if (pending) begin
                exp_word[31:0]  = data_q[2*idx];
                exp_word[63:32] = (2*idx + 1 < n) ? data_q[2*idx+1] : 32'h0;
                chk("out_data", out_data, exp_word);
                chk("out_last", out_last, (idx == words - 1));
            end
            done_due = 0;
            start = 1'b0;
            if (pending) begin
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                end else begin
                    out_ready = ($urandom_range(99) < p_out);
                end
                in_valid = $urandom_range(1);
                in_data  = $urandom;
                if (out_ready) begin
                    idx++;
                    pending = 0;
                    if (idx == words) done_due = 1;
                end
            end else begin
                out_ready = $urandom_range(1);
                if (inject_start && ptr == 1 && !injected) begin
                    start = 1'b1;
                    element_count = 8'd6;
                    injected = 1;
                end
                if (gap_left > 0) begin
                    in_valid = 1'b0;
                    gap_left--;
                end else begin
                    in_valid = ($urandom_range(99) < p_in);
                end
                in_data = in_valid ? data_q[ptr] : $urandom;
                if (in_valid) begin
                    ptr++;
                    if (ptr == 1) gap_left = stall_gap;
                    if (ptr % 2 == 0 || ptr == n) pending = 1;
                end
            end
            cyc++;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $error("FAIL timeout observed=%0d words expected=%0d", idx, words);
                break;
            end
            @(negedge clock);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; element_count = '0;
        repeat (2) begin
            @(negedge clock);
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_done", done, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; element_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        set_knobs(100, 100, 0, 0, 0);
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        reset_n = 1'b1;

        // Basic pack of four known elements
        data_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        run_op(4);

        // Odd tail
        data_q = '{32'hA, 32'hB, 32'hC};
        run_op(3);

        // Backpressure: three stalled cycles after out_valid rises
        set_knobs(100, 100, 3, 0, 0);
        fill_random(2);
        run_op(2);

        // Input stall between elements
        set_knobs(100, 100, 0, 2, 0);
        fill_random(2);
        run_op(2);

        // Zero count
        set_knobs(100, 100, 0, 0, 0);
        run_op(0);

        // Reset mid-operation after one input transfer
        @(negedge clock);
        start = 1'b1; element_count = 8'd4;
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        @(negedge clock);
        in_valid = 1'b0; reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_out_data", out_data, 0);
        reset_n = 1'b1;
        fill_random(2);
        run_op(2);

        // start while busy is ignored
        set_knobs(100, 100, 0, 1, 1);
        fill_random(2);
        run_op(2);

        // Randomized operations with random stalls on both sides
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(20, 1);
            set_knobs(60, 60, 0, 0, 0);
            fill_random(n);
            run_op(n);
        end

        // Maximum count: 128 words, last one a tail
        set_knobs(100, 100, 0, 0, 0);
        fill_random(255);
        run_op(255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
